disp_scan: RTL

Time-multiplexed seven-segment scanner; consumes the BCD magnitude digits and 4-bit sign code produced by the binary-to-BCD converter and drives a common segment bus plus one enable per digit position.
- Values are double-buffered: a load strobe captures into a pending register; the visible register updates only at a frame boundary, so a frame never shows mixed old and new digits.
- Optional leading-zero blanking.
- Sits between the converter and the board pins.

---
 rtl/disp_pkg.sv | 28 ++
 rtl/disp_scan_if.sv | 27 ++
 rtl/seg7_dec.sv | 32 +++
 rtl/disp_scan.sv | 117 +++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_pkg : code points and seven-segment glyphs shared by the scanner      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package disp_pkg;

  localparam logic [3:0] SGN_MINUS  = 4'b1010;
  localparam logic [3:0] SGN_BLANK  = 4'b1111;
  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Active-high, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage
`default_nettype wire

// File: rtl/disp_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_scan_if : converter-side digit bus and pin-side scan outputs          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface disp_scan_if #(
  parameter int DIGITS = 2
);
  logic [DIGITS*4-1:0] bcd;
  logic [3:0]          bcd_sgn;
  logic                load;
  logic                blank_lz;
  logic [6:0]          seg;
  logic [DIGITS:0]     dig_en;
  logic                frame_done;

  modport master (
    output bcd, bcd_sgn, load, blank_lz,
    input  seg, dig_en, frame_done
  );

  modport slave (
    input  bcd, bcd_sgn, load, blank_lz,
    output seg, dig_en, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg7_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_dec : 4-bit code to active-high segments (10 = dash, 11-15 = blank)   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seg7_dec
  import disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    case (code)
      4'd0:      seg = GLYPH_0;
      4'd1:      seg = GLYPH_1;
      4'd2:      seg = GLYPH_2;
      4'd3:      seg = GLYPH_3;
      4'd4:      seg = GLYPH_4;
      4'd5:      seg = GLYPH_5;
      4'd6:      seg = GLYPH_6;
      4'd7:      seg = GLYPH_7;
      4'd8:      seg = GLYPH_8;
      4'd9:      seg = GLYPH_9;
      CODE_DASH: seg = GLYPH_DASH;
      default:   seg = GLYPH_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/disp_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_scan : double-buffered, time-multiplexed seven-segment scanner        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module disp_scan
  import disp_pkg::*;
#(
  parameter int DIGITS         = 2,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  disp_scan_if.slave    bus
);

  localparam int N  = DIGITS + 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(N);

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(N - 1);
  localparam logic [6:0]    SEG_OFF    = {7{SEG_ACTIVE_LOW}};
  localparam logic [N-1:0]  DIG_OFF    = {N{DIG_ACTIVE_LOW}};

  logic [PW-1:0]  r_presc;
  logic [SW-1:0]  r_slot;
  logic [4*N-1:0] r_pend;
  logic [4*N-1:0] r_vis;
  logic           r_pend_vld;
  logic           r_wrap_d;

  logic           w_wrap;
  logic [N-1:0]   w_lz;
  logic [3:0]     w_nib;
  logic           w_sel_lz;
  logic [3:0]     w_code;
  logic [6:0]     w_glyph;
  logic [N-1:0]   w_onehot;

  assign w_wrap = (r_presc == PRESC_LAST) && (r_slot == SLOT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_slot  <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
      r_slot  <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // A load coinciding with the wrap commits the old pending value first,
  // then holds the new one for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '1;
      r_vis      <= '1;
      r_pend_vld <= 1'b0;
      r_wrap_d   <= 1'b0;
    end else begin
      r_wrap_d <= w_wrap;
      if (w_wrap && r_pend_vld)
        r_vis <= r_pend;
      if (bus.load) begin
        r_pend     <= {bus.bcd_sgn, bus.bcd};
        r_pend_vld <= 1'b1;
      end else if (w_wrap) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  // Magnitude digit i is a leading zero when it and everything above it is 0
  always_comb begin
    w_lz = '0;
    for (int i = 1; i < DIGITS; i++)
      w_lz[i] = ((r_vis[DIGITS*4-1:0] >> (4 * i)) == '0);
  end

  always_comb begin
    w_nib    = CODE_BLANK;
    w_sel_lz = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r_slot == SW'(i)) begin
        w_nib    = r_vis[i*4 +: 4];
        w_sel_lz = w_lz[i];
      end
    end
  end

  assign w_code   = (bus.blank_lz && w_sel_lz) ? CODE_BLANK : w_nib;
  assign w_onehot = N'(1) << r_slot;

  seg7_dec u_dec (
    .code (w_code),
    .seg  (w_glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg        <= SEG_OFF;
      bus.dig_en     <= DIG_OFF;
      bus.frame_done <= 1'b0;
    end else begin
      bus.seg        <= SEG_ACTIVE_LOW ? ~w_glyph : w_glyph;
      bus.dig_en     <= w_onehot ^ DIG_OFF;
      bus.frame_done <= r_wrap_d;
    end
  end

endmodule
`default_nettype wire
